bcd_display_scan: RTL

- Upstream time-multiplexing scanner for the 4-digit seven-segment display.
- Holds a 4-digit packed-BCD value and cycles through the digits at a divided refresh rate.
- Each cycle it drives one BCD nibble plus a one-hot, active-high digit select (`anode_switches`) into the BCD-to-seven-segment decoder stage.
- New values arrive over a valid/ready handshake and are applied only at frame boundaries, so a frame never shows part of the old value and part of the new one.

---
 rtl/bcd_display_scan.sv | 110 +++++++++++
 1 files changed

// File: rtl/bcd_display_scan.sv
// rtl/bcd_display_scan.sv - time-multiplexed 4-digit BCD scanner with frame-aligned value updates
module bcd_display_scan #(
    parameter int REFRESH_DIV = 100000,
    parameter int CNT_W       = 17
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        blank_lz,
    input  logic [15:0] value_in,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [3:0]  bcd,
    output logic [3:0]  anode_switches,
    output logic        frame_done,
    output logic        bcd_err
);

    localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] prescaler;
    logic [1:0]       idx;
    logic [15:0]      active;
    logic [15:0]      pending;
    logic             pending_full;

    logic             tick;
    logic             boundary;
    logic             load;
    logic             promote;
    logic             blanked;
    logic             err_next;
    logic [3:0]       cur_nibble;

    assign tick     = enable && (prescaler == PRESC_LAST);
    assign boundary = tick && (idx == 2'd3);
    assign in_ready = ~pending_full;
    assign load     = in_valid && ~pending_full;
    // While dark there is no frame to tear, so a pending value is applied immediately.
    assign promote  = pending_full && (boundary || !enable);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
            idx       <= 2'd0;
        end else if (!enable) begin
            prescaler <= '0;
            idx       <= 2'd0;
        end else if (tick) begin
            prescaler <= '0;
            idx       <= idx + 2'd1;
        end else begin
            prescaler <= prescaler + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active       <= 16'h0000;
            pending      <= 16'h0000;
            pending_full <= 1'b0;
        end else if (promote) begin
            active       <= pending;
            pending_full <= 1'b0;
        end else if (load) begin
            pending      <= value_in;
            pending_full <= 1'b1;
        end
    end

    always_comb begin
        cur_nibble = active[{idx, 2'b00} +: 4];
        blanked    = 1'b0;
        if (blank_lz) begin
            case (idx)
                2'd1:    blanked = (active[15:4] == 12'h000);
                2'd2:    blanked = (active[15:8] == 8'h00);
                2'd3:    blanked = (active[15:12] == 4'h0);
                default: blanked = 1'b0;
            endcase
        end
    end

    always_comb begin
        err_next = 1'b0;
        for (int d = 0; d < 4; d++) begin
            if (active[4*d +: 4] > 4'd9) err_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd            <= 4'h0;
            anode_switches <= 4'b0000;
            frame_done     <= 1'b0;
            bcd_err        <= 1'b0;
        end else begin
            frame_done <= boundary;
            bcd_err    <= err_next;
            if (!enable || blanked) begin
                bcd            <= 4'h0;
                anode_switches <= 4'b0000;
            end else begin
                bcd            <= cur_nibble;
                anode_switches <= 4'b0001 << idx;
            end
        end
    end

endmodule
